// File: rtl/encoder_position_tracker_pkg.sv
// Shared types and defaults for the encoder position tracker slice.
// Optional stall detection is enabled by defining TRACKER_STALL_DET_EN.
package encoder_pkg;

    localparam int POS_W_DEFAULT      = 16;
    localparam int VEL_W_DEFAULT      = 12;
    localparam int VEL_WINDOW_DEFAULT = 50000;

    typedef logic signed [POS_W_DEFAULT-1:0] pos_t;
    typedef logic signed [VEL_W_DEFAULT-1:0] vel_t;

    localparam pos_t LIM_MIN_DEFAULT = -16'sd30000;
    localparam pos_t LIM_MAX_DEFAULT = 16'sd30000;

    // Encoded as {ccw, cw} so the decode is a plain cast.
    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b10,
        STEP_BOTH = 2'b11
    } step_e;

    function automatic step_e decode_step(input logic cw, input logic ccw);
        return step_e'({ccw, cw});
    endfunction

endpackage

// File: rtl/encoder_position_tracker_if.sv
// Bus between the controller/status side and the position tracker.
// Stall signals exist only when TRACKER_STALL_DET_EN is defined.
interface encoder_position_tracker_if #(
    parameter int POS_W = 16,
    parameter int VEL_W = 12
);
    logic                    cw;
    logic                    ccw;
    logic                    zero_req;
    logic                    preset_en;
    logic signed [POS_W-1:0] preset_val;
    logic                    err_clr;
    logic signed [POS_W-1:0] pos;
    logic signed [VEL_W-1:0] vel;
    logic                    vel_valid;
    logic                    at_min;
    logic                    at_max;
    logic                    err;
`ifdef TRACKER_STALL_DET_EN
    logic                    motion_cmd;
    logic                    stall;
`endif

    modport master (
        output cw, ccw, zero_req, preset_en, preset_val, err_clr,
        input  pos, vel, vel_valid, at_min, at_max, err
`ifdef TRACKER_STALL_DET_EN
        , output motion_cmd
        , input  stall
`endif
    );

    modport slave (
        input  cw, ccw, zero_req, preset_en, preset_val, err_clr,
        output pos, vel, vel_valid, at_min, at_max, err
`ifdef TRACKER_STALL_DET_EN
        , input  motion_cmd
        , output stall
`endif
    );

endinterface

// File: rtl/encoder_position_tracker_vel_window.sv
// Windowed velocity estimator: counts signed steps over a fixed window of
// clock cycles and publishes the total with a one-cycle valid pulse.
module encoder_vel_window
    import encoder_pkg::*;
#(
    parameter int VEL_W      = VEL_W_DEFAULT,
    parameter int VEL_WINDOW = VEL_WINDOW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cw,
    input  logic                    ccw,
    output logic signed [VEL_W-1:0] vel,
    output logic                    vel_valid
);

    localparam int CNT_W = (VEL_WINDOW > 2) ? $clog2(VEL_WINDOW) : 1;
    localparam logic [CNT_W-1:0]        WIN_LAST  = CNT_W'(VEL_WINDOW - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
    localparam logic signed [VEL_W-1:0] DELTA_ONE = VEL_W'(1);
    localparam logic signed [VEL_W-1:0] DELTA_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] DELTA_MIN = -DELTA_MAX;

    logic [CNT_W-1:0]        win_cnt_r;
    logic signed [VEL_W-1:0] delta_r;
    logic signed [VEL_W-1:0] delta_next_s;
    logic signed [VEL_W-1:0] vel_r;
    logic                    vel_valid_r;
    step_e                   step_s;

    assign step_s = decode_step(cw, ccw);

    // Saturating step accumulation; limit-blocked steps still count here.
    always_comb begin
        delta_next_s = delta_r;
        case (step_s)
            STEP_UP: begin
                if (delta_r != DELTA_MAX) begin
                    delta_next_s = delta_r + DELTA_ONE;
                end else begin
                    delta_next_s = delta_r;
                end
            end
            STEP_DOWN: begin
                if (delta_r != DELTA_MIN) begin
                    delta_next_s = delta_r - DELTA_ONE;
                end else begin
                    delta_next_s = delta_r;
                end
            end
            default: delta_next_s = delta_r;
        endcase
    end

    // Window counter and publish: the boundary cycle's own step is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r   <= {CNT_W{1'b0}};
            delta_r     <= {VEL_W{1'b0}};
            vel_r       <= {VEL_W{1'b0}};
            vel_valid_r <= 1'b0;
        end else if (win_cnt_r == WIN_LAST) begin
            win_cnt_r   <= {CNT_W{1'b0}};
            delta_r     <= {VEL_W{1'b0}};
            vel_r       <= delta_next_s;
            vel_valid_r <= 1'b1;
        end else begin
            win_cnt_r   <= win_cnt_r + CNT_ONE;
            delta_r     <= delta_next_s;
            vel_valid_r <= 1'b0;
        end
    end

    assign vel       = vel_r;
    assign vel_valid = vel_valid_r;

endmodule

// File: rtl/encoder_position_tracker.sv
// Joint position tracker: saturating signed position with zero/preset,
// sticky double-step error and windowed velocity.
// Optional stall detector enabled by defining TRACKER_STALL_DET_EN.
module encoder_position_tracker
    import encoder_pkg::*;
#(
    parameter int                      POS_W      = POS_W_DEFAULT,
    parameter int                      VEL_W      = VEL_W_DEFAULT,
    parameter int                      VEL_WINDOW = VEL_WINDOW_DEFAULT,
    parameter logic signed [POS_W-1:0] LIM_MIN    = LIM_MIN_DEFAULT,
    parameter logic signed [POS_W-1:0] LIM_MAX    = LIM_MAX_DEFAULT
`ifdef TRACKER_STALL_DET_EN
    , parameter int                    STALL_CYCLES = 1000000
`endif
) (
    input logic                      clk,
    input logic                      rst_n,
    encoder_position_tracker_if.slave bus
);

    localparam logic signed [POS_W:0] MIN_EXT = {LIM_MIN[POS_W-1], LIM_MIN};
    localparam logic signed [POS_W:0] MAX_EXT = {LIM_MAX[POS_W-1], LIM_MAX};
    localparam logic signed [POS_W:0] ONE_EXT = (POS_W+1)'(1);

    logic signed [POS_W-1:0] pos_r;
    logic signed [POS_W-1:0] pos_next_s;
    logic signed [POS_W:0]   pos_ext_s;
    logic signed [POS_W:0]   preset_ext_s;
    logic                    err_r;
    step_e                   step_s;

    // Keeps arithmetic one bit wider than pos so clamping never sees a wrap.
    function automatic logic signed [POS_W-1:0] clamp_pos(input logic signed [POS_W:0] v);
        logic signed [POS_W-1:0] r;
        if (v < MIN_EXT) begin
            r = LIM_MIN;
        end else if (v > MAX_EXT) begin
            r = LIM_MAX;
        end else begin
            r = v[POS_W-1:0];
        end
        return r;
    endfunction

    assign step_s       = decode_step(bus.cw, bus.ccw);
    assign pos_ext_s    = {pos_r[POS_W-1], pos_r};
    assign preset_ext_s = {bus.preset_val[POS_W-1], bus.preset_val};

    // Next position: zero beats preset beats step; everything but zero is clamped.
    always_comb begin
        pos_next_s = pos_r;
        if (bus.zero_req) begin
            pos_next_s = {POS_W{1'b0}};
        end else if (bus.preset_en) begin
            pos_next_s = clamp_pos(preset_ext_s);
        end else begin
            case (step_s)
                STEP_UP:   pos_next_s = clamp_pos(pos_ext_s + ONE_EXT);
                STEP_DOWN: pos_next_s = clamp_pos(pos_ext_s - ONE_EXT);
                default:   pos_next_s = pos_r;
            endcase
        end
    end

    // Position register and sticky error; a new double step beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= {POS_W{1'b0}};
            err_r <= 1'b0;
        end else begin
            pos_r <= pos_next_s;
            if (step_s == STEP_BOTH) begin
                err_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    encoder_vel_window #(
        .VEL_W      (VEL_W),
        .VEL_WINDOW (VEL_WINDOW)
    ) u_vel_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .cw        (bus.cw),
        .ccw       (bus.ccw),
        .vel       (bus.vel),
        .vel_valid (bus.vel_valid)
    );

    assign bus.pos    = pos_r;
    assign bus.err    = err_r;
    assign bus.at_min = (pos_r == LIM_MIN);
    assign bus.at_max = (pos_r == LIM_MAX);

`ifdef TRACKER_STALL_DET_EN
    localparam int SC_W = $clog2(STALL_CYCLES + 1);
    localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_CYCLES);
    localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);

    logic [SC_W-1:0] stall_cnt_r;
    logic [SC_W-1:0] stall_cnt_next_s;
    logic            stall_r;

    // Stall counter: runs while motion is commanded without steps, saturating.
    always_comb begin
        stall_cnt_next_s = stall_cnt_r;
        if (!bus.motion_cmd || bus.cw || bus.ccw) begin
            stall_cnt_next_s = {SC_W{1'b0}};
        end else if (stall_cnt_r != STALL_LAST) begin
            stall_cnt_next_s = stall_cnt_r + SC_ONE;
        end else begin
            stall_cnt_next_s = stall_cnt_r;
        end
    end

    // Stall flag sets on reaching the threshold, sticky until clear or motion drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {SC_W{1'b0}};
            stall_r     <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_next_s;
            if (!bus.motion_cmd) begin
                stall_r <= 1'b0;
            end else if ((stall_cnt_next_s == STALL_LAST) && (stall_cnt_r != STALL_LAST)) begin
                stall_r <= 1'b1;
            end else if (bus.err_clr) begin
                stall_r <= 1'b0;
            end else begin
                stall_r <= stall_r;
            end
        end
    end

    assign bus.stall = stall_r;
`endif

endmodule

// File: tb/tb_encoder_position_tracker.sv
// Directed, scoreboard-based bench for encoder_position_tracker.
module tb_encoder_position_tracker;

    localparam int WIN  = 100;
    localparam int LMIN = -30000;
    localparam int LMAX = 30000;
    localparam int DMAX = 2047;
    localparam int STALL_N = 50;

    typedef struct {
        int   pos;
        logic err;
        logic vv;
        int   vel;
        logic stall;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    int   m_pos, m_vel, m_delta, m_wcnt, m_scnt;
    logic m_err, m_stall;
`ifdef TRACKER_STALL_DET_EN
    logic motion_m;
`endif

    encoder_position_tracker_if #(.POS_W(16), .VEL_W(12)) bus ();

`ifdef TRACKER_STALL_DET_EN
    encoder_position_tracker #(.VEL_WINDOW(WIN), .STALL_CYCLES(STALL_N)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`else
    encoder_position_tracker #(.VEL_WINDOW(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_vel = 0; m_delta = 0; m_wcnt = 0; m_scnt = 0;
        m_err = 1'b0; m_stall = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model, push, then pop and compare.
    task automatic drive(input logic c, input logic cc, input logic z, input logic p,
                         input int pv, input logic ec);
        exp_t e;
        exp_t g;
        int   old_s;
        bus.cw = c; bus.ccw = cc; bus.zero_req = z; bus.preset_en = p;
        bus.preset_val = 16'(pv); bus.err_clr = ec;
`ifdef TRACKER_STALL_DET_EN
        bus.motion_cmd = motion_m;
`endif
        if (z) m_pos = 0;
        else if (p) m_pos = (pv < LMIN) ? LMIN : ((pv > LMAX) ? LMAX : pv);
        else if (c && !cc) m_pos = (m_pos >= LMAX) ? LMAX : m_pos + 1;
        else if (cc && !c) m_pos = (m_pos <= LMIN) ? LMIN : m_pos - 1;
        m_err = (c && cc) || (m_err && !ec);
        if (c && !cc) begin
            if (m_delta < DMAX) m_delta++;
        end else if (cc && !c) begin
            if (m_delta > -DMAX) m_delta--;
        end
        if (m_wcnt == WIN - 1) begin
            m_vel = m_delta; m_delta = 0; m_wcnt = 0; e.vv = 1'b1;
        end else begin
            m_wcnt++; e.vv = 1'b0;
        end
`ifdef TRACKER_STALL_DET_EN
        old_s = m_scnt;
        if (!motion_m || c || cc) m_scnt = 0;
        else if (m_scnt < STALL_N) m_scnt++;
        if (!motion_m) m_stall = 1'b0;
        else if (m_scnt == STALL_N && old_s != STALL_N) m_stall = 1'b1;
        else if (ec) m_stall = 1'b0;
`else
        old_s = 0;
`endif
        e.pos = m_pos; e.err = m_err; e.vel = m_vel; e.stall = m_stall + 1'b0 * old_s[0];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("pos", bus.pos, g.pos);
        chk("at_min", bus.at_min, (g.pos == LMIN) ? 1 : 0);
        chk("at_max", bus.at_max, (g.pos == LMAX) ? 1 : 0);
        chk("err", bus.err, g.err);
        chk("vel_valid", bus.vel_valid, g.vv);
        chk("vel", bus.vel, g.vel);
`ifdef TRACKER_STALL_DET_EN
        chk("stall", bus.stall, g.stall);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pos"}, bus.pos, 0);
        chk({tag, "_vel"}, bus.vel, 0);
        chk({tag, "_vv"}, bus.vel_valid, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_min"}, bus.at_min, 0);
        chk({tag, "_max"}, bus.at_max, 0);
    endtask

    initial begin
        checks = 0; errors = 0;
        bus.cw = 1'b0; bus.ccw = 1'b0; bus.zero_req = 1'b0; bus.preset_en = 1'b0;
        bus.preset_val = 16'sd0; bus.err_clr = 1'b0;
`ifdef TRACKER_STALL_DET_EN
        motion_m = 1'b0; bus.motion_cmd = 1'b0;
`endif
        rst_n = 1'b0;
        model_reset();
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Counting up and down, one-cycle latency per step
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("pos_after_10cw", bus.pos, 10);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("pos_after_3ccw", bus.pos, 7);

        // Preset near the top, then saturate at LIM_MAX
        drive(1'b0, 1'b0, 1'b0, 1'b1, 29998, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("pos_sat_max", bus.pos, 30000);
        chk("at_max_sat", bus.at_max, 1);

        // Out-of-range presets clamp
        drive(1'b0, 1'b0, 1'b0, 1'b1, 31000, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, -32000, 1'b0);
        chk("preset_clamp_min", bus.pos, LMIN);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Double pulse error: sticky, cleared, set wins over clear
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("err_set", bus.err, 1);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("err_cleared", bus.err, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        chk("err_set_wins", bus.err, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        // zero_req beats preset and step
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1234, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 555, 1'b0);
        chk("zero_priority", bus.pos, 0);

        // Full window with 7 cw pulses, the last on the boundary cycle
        for (int i = 0; i < WIN && m_wcnt != 0; i++) idle(1);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < WIN && m_wcnt != WIN - 1; i++) idle(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("vel_7", bus.vel, 7);
        chk("vel_valid_pulse", bus.vel_valid, 1);
        idle(1);
        chk("vel_valid_single", bus.vel_valid, 0);

        // Mid-window reset discards the partial window
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(20);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle(WIN - 3);
        chk("vel_after_reset", bus.vel, 3);

`ifdef TRACKER_STALL_DET_EN
        // Stall detection: a step restarts the count
        motion_m = 1'b1;
        idle(30);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle(STALL_N - 1);
        chk("stall_not_yet", bus.stall, 0);
        idle(1);
        chk("stall_set", bus.stall, 1);
        idle(3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("stall_clr", bus.stall, 0);
        motion_m = 1'b0;
        idle(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_position_tracker.md
Name: encoder_position_tracker

Overview:
- Consumes the one-cycle `cw`/`ccw` step pulses from the quadrature decoder stage. Both stages run in the same `clk` domain.
- Maintains a signed, saturating joint position with software zero/preset.
- Produces a windowed velocity estimate and limit/error flags.
- Feeds the joint controller and the status register block.

Parameters:
- POS_W, 16: width of signed position.
- VEL_W, 12: width of signed velocity (steps per window).
- VEL_WINDOW, 50000: velocity sample window in `clk` cycles (≥2).
- LIM_MIN, -16'sd30000: lowest legal position (signed, POS_W).
- LIM_MAX, 16'sd30000: highest legal position (signed, POS_W). LIM_MIN < LIM_MAX.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cw  in  1  clockwise step pulse from decoder.
- ccw  in  1  counterclockwise step pulse from decoder.
- zero_req  in  1  one-cycle strobe: position := 0.
- preset_en  in  1  one-cycle strobe: position := preset_val.
- preset_val  in  POS_W  signed preset value.
- err_clr  in  1  clears sticky error.
- pos  out  POS_W  signed current position.
- vel  out  VEL_W  signed step count of the last completed window.
- vel_valid  out  1  one-cycle pulse when `vel` updates.
- at_min  out  1  pos == LIM_MIN.
- at_max  out  1  pos == LIM_MAX.
- err  out  1  sticky error: `cw` and `ccw` were high in the same cycle.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All state updates on `posedge clk`; `rst_n` low clears immediately.
- Reset values:
  - pos=0, vel=0, vel_valid=0, err=0.
  - Window counter=0, delta accumulator=0.
  - at_min/at_max reflect pos=0 (normally 0).
- Position update priority (highest first) each cycle: zero_req > preset_en > step.
- zero_req: pos <= 0 next cycle.
- preset_en: pos <= clamp(preset_val, LIM_MIN, LIM_MAX).
- Step rules:
  - cw only: pos+1, but holds at LIM_MAX.
  - ccw only: pos-1, but holds at LIM_MIN.
  - Both high: pos unchanged, err <= 1.
  - Neither: hold.
- Latency: the step pulse in cycle N is visible on `pos` in cycle N+1. at_min/at_max are combinational from the `pos` register.
- Error handling:
  - err is sticky until an err_clr cycle.
  - A simultaneous err_clr and new error leaves err = 1 (set wins).
- Velocity:
  - The window counter runs 0..VEL_WINDOW-1 continuously and wraps.
  - delta accumulates +1 per cw-only cycle and -1 per ccw-only cycle, saturating at ±(2^(VEL_W-1)-1).
  - delta counts every encoder step, including steps blocked by position limits.
  - zero_req and preset_en do not affect delta.
- Window end (counter == VEL_WINDOW-1):
  - vel <= delta including that cycle's step.
  - vel_valid pulses for 1 cycle.
  - delta <= 0.
  - Counter wraps to 0.
- Widths: all position arithmetic is done in POS_W+1 bits, then clamped. There is no wrap-around of `pos`, ever.
- Reset mid-window: the window restarts from 0 and the partial delta is discarded.

Optional Feature:
- Macro: TRACKER_STALL_DET_EN.
- When defined:
  - Add parameter STALL_CYCLES (default 1000000).
  - Add input `motion_cmd` (1) and output `stall` (1).
  - A stall counter increments each cycle where motion_cmd=1 and no step occurs.
  - It clears on any step or when motion_cmd=0.
  - stall is set when the counter reaches STALL_CYCLES, and is sticky until err_clr or motion_cmd=0.
  - The stall counter saturates rather than wrapping.
- When undefined: no extra ports, logic or parameter.

Decomposition:
- Package `encoder_pkg`:
  - POS_W/VEL_W default localparams.
  - typedefs `pos_t` (logic signed [POS_W-1:0]) and `vel_t`.
  - Default limit constants.
- One natural sub-module, `encoder_vel_window`: window counter, delta accumulator, vel/vel_valid. It is instantiated once and shares the cw/ccw inputs.

Test Plan:
- Reset, then 10 cw pulses: pos=10; then 3 ccw pulses: pos=7. Each step is visible 1 cycle after its pulse.
- preset_en with preset_val=29998, then 5 cw pulses: pos=30000 and at_max=1. delta still counts +5.
- cw=ccw=1 in one cycle: pos unchanged and err=1 stays set. err_clr clears it. err_clr together with a new double pulse leaves err=1.
- VEL_WINDOW=100 with 7 cw pulses in the window: vel=7 and vel_valid is high for exactly 1 cycle at the window boundary. A step on the boundary cycle is included in that window's vel.
- zero_req with preset_en and cw in the same cycle: pos=0 next cycle. rst_n asserted mid-window: all outputs return to reset values asynchronously.
- With TRACKER_STALL_DET_EN and STALL_CYCLES=50: motion_cmd=1 with no steps gives stall=1 at cycle 50. A step before cycle 50 keeps stall=0.
